// File: rtl/dmem_wait_responder_if.sv
// Load/store request bus between the core (master) and a data-memory responder (slave).
interface dmem_if;
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, a, wd,
        input  rd, ready, err, busy
    );

    modport slave (
        input  req, we, a, wd,
        output rd, ready, err, busy
    );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a configurable number of wait states before a one-cycle
// ready pulse; used to exercise the core's stall path on slow memory.
module dmem_wait_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_BITS   = 6
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;

    logic                 lat_we;
    logic                 lat_we_next;
    logic                 lat_mis;
    logic                 lat_mis_next;
    logic [ADDR_BITS-1:0] lat_idx;
    logic [ADDR_BITS-1:0] lat_idx_next;
    logic [DATA_W-1:0]    lat_wd;
    logic [DATA_W-1:0]    lat_wd_next;

    logic                 ready_q;
    logic                 ready_next;
    logic                 err_q;
    logic                 err_next;
    logic                 busy_q;
    logic                 busy_next;
    logic [DATA_W-1:0]    rd_q;
    logic [DATA_W-1:0]    rd_next;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic                 commit_c;

    // State, latched request and registered outputs; reset aborts any pending access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            lat_we  <= 1'b0;
            lat_mis <= 1'b0;
            lat_idx <= '0;
            lat_wd  <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            lat_we  <= lat_we_next;
            lat_mis <= lat_mis_next;
            lat_idx <= lat_idx_next;
            lat_wd  <= lat_wd_next;
            ready_q <= ready_next;
            err_q   <= err_next;
            busy_q  <= busy_next;
            rd_q    <= rd_next;
        end
    end

    // Next state and the output values for the cycle that state will occupy.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        lat_we_next  = lat_we;
        lat_mis_next = lat_mis;
        lat_idx_next = lat_idx;
        lat_wd_next  = lat_wd;

        unique case (state)
            S_IDLE: begin
                if (bus.req) begin
                    lat_we_next  = bus.we;
                    lat_mis_next = |bus.a[1:0];
                    lat_idx_next = bus.a[ADDR_BITS+1:2];
                    lat_wd_next  = bus.wd;
                    if (WAIT_CYCLES == 0) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        ready_next = (state_next == S_RESP);
        busy_next  = (state_next != S_IDLE);
        err_next   = ready_next & lat_mis_next;
        rd_next    = '0;
        if (ready_next && !lat_we_next && !lat_mis_next) begin
            rd_next = mem[lat_idx_next];
        end
    end

    // Stores commit on the edge that closes the ready cycle; misaligned stores are dropped.
    assign commit_c = (state == S_RESP) && !reset && lat_we && !lat_mis;

    always_ff @(posedge clk) begin
        if (commit_c) begin
            mem[lat_idx] <= lat_wd;
        end
    end

    assign bus.rd    = rd_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench: a transaction-level model predicts every output each cycle for
// a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance, with directed literal checks on top.
module tb_dmem_wait_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req [2];
    logic        we  [2];
    logic [31:0] a   [2];
    logic [31:0] wd  [2];
    logic [31:0] rd_o    [2];
    logic        ready_o [2];
    logic        err_o   [2];
    logic        busy_o  [2];

    dmem_if if0 ();
    dmem_if if1 ();

    assign if0.req = req[0];
    assign if0.we  = we[0];
    assign if0.a   = a[0];
    assign if0.wd  = wd[0];
    assign if1.req = req[1];
    assign if1.we  = we[1];
    assign if1.a   = a[1];
    assign if1.wd  = wd[1];
    assign rd_o[0] = if0.rd;
    assign rd_o[1] = if1.rd;
    assign ready_o[0] = if0.ready;
    assign ready_o[1] = if1.ready;
    assign err_o[0] = if0.err;
    assign err_o[1] = if1.err;
    assign busy_o[0] = if0.busy;
    assign busy_o[1] = if1.busy;

    dmem_wait_responder #(.WAIT_CYCLES(2), .ADDR_BITS(6)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    dmem_wait_responder #(.WAIT_CYCLES(0), .ADDR_BITS(6)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
        end
    endtask

    function automatic int wcyc(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Transaction model: one pending access per instance, due at an absolute cycle number.
    int          cyc = 0;
    bit          chk_en = 1'b0;
    bit          m_pend [2] = '{0, 0};
    int          m_done [2];
    bit          m_we   [2];
    bit          m_mis  [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    logic [31:0] mm [2][64];
    bit          mv [2][64];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_pend[d] = 1'b0;
            end else if (m_pend[d]) begin
                if (cyc == m_done[d]) begin
                    if (m_we[d] && !m_mis[d]) begin
                        mm[d][m_idx[d]] = m_wd[d];
                        mv[d][m_idx[d]] = 1'b1;
                    end
                    m_pend[d] = 1'b0;
                end
            end else if (req[d]) begin
                m_pend[d] = 1'b1;
                m_done[d] = cyc + wcyc(d) + 1;
                m_we[d]   = we[d];
                m_mis[d]  = (a[d] % 4) != 0;
                m_idx[d]  = int'((a[d] / 4) % 64);
                m_wd[d]   = wd[d];
            end
        end
        if (reset) chk_en = 1'b1;
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                bit          e_rdy;
                bit          rd_known;
                logic [31:0] e_rd;
                e_rdy    = m_pend[d] && (cyc == m_done[d]);
                rd_known = 1'b1;
                e_rd     = '0;
                if (e_rdy && !m_we[d] && !m_mis[d]) begin
                    if (mv[d][m_idx[d]]) e_rd = mm[d][m_idx[d]];
                    else rd_known = 1'b0;
                end
                chk("ready", d, 32'(ready_o[d]), 32'(e_rdy));
                chk("err", d, 32'(err_o[d]), 32'(e_rdy && m_mis[d]));
                chk("busy", d, 32'(busy_o[d]), 32'(m_pend[d]));
                if (rd_known) chk("rd", d, rd_o[d], e_rd);
            end
        end
    end

    // Drives one access, holds req until ready, drops it in the ready cycle.
    task automatic xact(input int d, input logic w, input logic [31:0] addr, input logic [31:0] data,
                        output int lat, output int nbusy, output logic [31:0] rdv, output logic ev);
        lat = -1;
        nbusy = 0;
        rdv = '0;
        ev = 1'b0;
        @(negedge clk);
        req[d] = 1'b1;
        we[d]  = w;
        a[d]   = addr;
        wd[d]  = data;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (busy_o[d]) nbusy++;
            if (ready_o[d]) begin
                lat = t;
                rdv = rd_o[d];
                ev  = err_o[d];
                break;
            end
        end
        req[d] = 1'b0;
        if (lat < 0) chk("timeout", d, 32'(0), 32'(1));
    endtask

    initial begin
        int          lat;
        int          nb;
        logic [31:0] r;
        logic        e;
        int          first;
        int          second;
        int          n;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0;
            we[d]  = 1'b0;
            a[d]   = '0;
            wd[d]  = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 0, 32'(ready_o[0]), 32'(0));
        chk("rst_busy", 0, 32'(busy_o[0]), 32'(0));
        chk("rst_err", 0, 32'(err_o[0]), 32'(0));
        chk("rst_rd", 0, rd_o[0], 32'h0);

        // Store with two wait states.
        xact(0, 1'b1, 32'h54, 32'h7, lat, nb, r, e);
        chk("t1_latency", 0, 32'(lat), 32'(3));
        chk("t1_busy_cycles", 0, 32'(nb), 32'(3));
        chk("t1_err", 0, 32'(e), 32'(0));
        @(negedge clk);
        chk("t1_model_mem21", 0, mm[0][21], 32'h7);

        // Load back the stored word.
        xact(0, 1'b0, 32'h54, 32'h0, lat, nb, r, e);
        chk("t2_latency", 0, 32'(lat), 32'(3));
        chk("t2_rd", 0, r, 32'h7);

        // Misaligned store must flag err and leave memory intact.
        xact(0, 1'b1, 32'h56, 32'hFFFF_FFFF, lat, nb, r, e);
        chk("t3_err", 0, 32'(e), 32'(1));
        xact(0, 1'b0, 32'h54, 32'h0, lat, nb, r, e);
        chk("t3_rd_unchanged", 0, r, 32'h7);
        xact(0, 1'b0, 32'h57, 32'h0, lat, nb, r, e);
        chk("t3_misload_err", 0, 32'(e), 32'(1));
        chk("t3_misload_rd", 0, r, 32'h0);

        // Address aliasing modulo depth.
        xact(0, 1'b1, 32'h100, 32'hABCD, lat, nb, r, e);
        xact(0, 1'b0, 32'h000, 32'h0, lat, nb, r, e);
        chk("t4_alias_rd", 0, r, 32'hABCD);

        // Back-to-back with req held through ready.
        first = -1;
        second = -1;
        @(negedge clk);
        req[0] = 1'b1;
        we[0]  = 1'b0;
        a[0]   = 32'h54;
        for (int t = 1; t <= 40 && second < 0; t++) begin
            @(negedge clk);
            if (ready_o[0]) begin
                if (first < 0) first = t;
                else second = t;
            end
        end
        req[0] = 1'b0;
        chk("t5_first", 0, 32'(first), 32'(3));
        chk("t5_spacing", 0, 32'(second - first), 32'(4));

        // Reset during the first wait cycle discards the store.
        xact(0, 1'b1, 32'h10, 32'h1234, lat, nb, r, e);
        @(negedge clk);
        req[0] = 1'b1;
        we[0]  = 1'b1;
        a[0]   = 32'h10;
        wd[0]  = 32'h55;
        @(negedge clk);
        chk("t6_busy_wait", 0, 32'(busy_o[0]), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        req[0] = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready_o[0]) n++;
        end
        chk("t6_no_ready", 0, 32'(n), 32'(0));
        xact(0, 1'b0, 32'h10, 32'h0, lat, nb, r, e);
        chk("t6_rd_prior", 0, r, 32'h1234);

        // Zero-wait instance.
        xact(1, 1'b1, 32'h20, 32'hCAFE_0001, lat, nb, r, e);
        chk("t7_store_latency", 1, 32'(lat), 32'(1));
        chk("t7_store_busy", 1, 32'(nb), 32'(1));
        xact(1, 1'b0, 32'h20, 32'h0, lat, nb, r, e);
        chk("t7_load_latency", 1, 32'(lat), 32'(1));
        chk("t7_load_rd", 1, r, 32'hCAFE_0001);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
